// File: rtl/io_bus_responder.sv
// CPU IO-bus peripheral: switch input, LED register, status, scratch and a
// transmit FIFO drained by a ready/valid sink. Reads are combinational.
module io_bus_responder #(
    parameter logic [7:0] BASE_ADDR   = 8'h01,
    parameter int         FIFO_DEPTH  = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_oszClk,
    input  logic       i_reset,
    input  logic       i_ioNCE,
    input  logic [7:0] i_ioAddress,
    input  logic       i_ioNOE,
    input  logic       i_ioNWE,
    input  logic [7:0] i_bus,
    output logic [7:0] o_bus,
    output logic       o_busNOE,
    input  logic [7:0] i_switches,
    output logic [7:0] o_leds,
    output logic [7:0] o_txData,
    output logic       o_txValid,
    input  logic       i_txReady
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        REG_SWITCHES = 3'd0,
        REG_LEDS     = 3'd1,
        REG_STATUS   = 3'd2,
        REG_TXFIFO   = 3'd3,
        REG_SCRATCH  = 3'd4
    } regSel_t;

    logic [SYNC_STAGES-1:0][7:0] syncReg;
    logic [7:0]    ledReg;
    logic [7:0]    scratchReg;
    logic          overflowFlag;
    logic          underflowFlag;
    logic          wrSeen;
    logic          rdSeen;
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic [7:0]    fifoMem [FIFO_DEPTH];

    logic          selected;
    regSel_t       regSel;
    logic          wrStrobe;
    logic          rdStrobe;
    logic          wrCommit;
    logic          rdFirst;
    logic          fifoEmpty;
    logic          fifoFull;
    logic          pushReq;
    logic          push;
    logic          pop;
    logic [4:0]    countWide;
    logic [3:0]    statusCount;
    logic [7:0]    statusValue;
    logic [7:0]    readValue;

    assign selected = !i_ioNCE && (i_ioAddress != 8'h00)
                      && (i_ioAddress >= BASE_ADDR)
                      && (i_ioAddress <= BASE_ADDR + 8'd4);
    assign regSel   = regSel_t'(3'(i_ioAddress - BASE_ADDR));

    // A low nWE wins over a low nOE: the cycle is a write and nobody drives.
    assign wrStrobe = selected && !i_ioNWE;
    assign rdStrobe = selected && !i_ioNOE && i_ioNWE;
    assign wrCommit = wrStrobe && !wrSeen;
    assign rdFirst  = rdStrobe && !rdSeen;

    assign fifoEmpty = (count == '0);
    assign fifoFull  = (count == CW'(FIFO_DEPTH));
    assign pop       = !fifoEmpty && i_txReady;
    assign pushReq   = wrCommit && (regSel == REG_TXFIFO);
    assign push      = pushReq && (!fifoFull || pop);

    assign countWide   = 5'(count);
    assign statusCount = (countWide > 5'd15) ? 4'hF : countWide[3:0];
    assign statusValue = {statusCount, underflowFlag, overflowFlag, fifoFull, fifoEmpty};

    always_ff @(posedge i_oszClk or posedge i_reset) begin
        if (i_reset) begin
            syncReg <= '0;
        end else begin
            syncReg <= {syncReg[SYNC_STAGES-2:0], i_switches};
        end
    end

    // NOTE: strobe history resets to "already seen" so a strobe held across reset release never commits.
    always_ff @(posedge i_oszClk or posedge i_reset) begin
        if (i_reset) begin
            ledReg        <= 8'h00;
            scratchReg    <= 8'h00;
            overflowFlag  <= 1'b0;
            underflowFlag <= 1'b0;
            wrSeen        <= 1'b1;
            rdSeen        <= 1'b1;
            wrPtr         <= '0;
            rdPtr         <= '0;
            count         <= '0;
        end else begin
            wrSeen <= wrStrobe;
            rdSeen <= rdStrobe;
            if (wrCommit) begin
                case (regSel)
                    REG_LEDS:    ledReg     <= i_bus;
                    REG_SCRATCH: scratchReg <= i_bus;
                    REG_STATUS: begin
                        overflowFlag  <= 1'b0;
                        underflowFlag <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (pushReq && fifoFull && !pop)
                overflowFlag <= 1'b1;
            if (rdFirst && (regSel == REG_TXFIFO) && fifoEmpty)
                underflowFlag <= 1'b1;
            if (push)
                wrPtr <= wrPtr + 1'b1;
            if (pop)
                rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; empty is tracked by count and the head is masked while empty.
    always_ff @(posedge i_oszClk) begin
        if (push)
            fifoMem[wrPtr] <= i_bus;
    end

    // NOTE: default assignment first keeps this purely combinational (no latch).
    always_comb begin
        readValue = 8'h00;
        case (regSel)
            REG_SWITCHES: readValue = syncReg[SYNC_STAGES-1];
            REG_LEDS:     readValue = ledReg;
            REG_STATUS:   readValue = statusValue;
            REG_TXFIFO:   readValue = fifoEmpty ? 8'h00 : fifoMem[rdPtr];
            REG_SCRATCH:  readValue = scratchReg;
            default:      readValue = 8'h00;
        endcase
    end

    assign o_busNOE  = !(rdStrobe && !i_reset);
    assign o_bus     = o_busNOE ? 8'h00 : readValue;
    assign o_leds    = ledReg;
    assign o_txValid = !fifoEmpty;
    assign o_txData  = fifoEmpty ? 8'h00 : fifoMem[rdPtr];

endmodule

// File: tb/tb_io_bus_responder.sv
// Directed bench for io_bus_responder: reset, decode, single-shot writes,
// FIFO overflow/drain, simultaneous push+drain, underflow and reset mid-strobe.
module tb_io_bus_responder;

    logic       oszClk = 1'b0;
    logic       reset;
    logic       ioNCE;
    logic [7:0] ioAddress;
    logic       ioNOE;
    logic       ioNWE;
    logic [7:0] busIn;
    logic [7:0] busOut;
    logic       busNOE;
    logic [7:0] switches;
    logic [7:0] leds;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady;

    int checks   = 0;
    int failures = 0;

    always #5 oszClk = ~oszClk;

    io_bus_responder #(
        .BASE_ADDR  (8'h01),
        .FIFO_DEPTH (8),
        .SYNC_STAGES(2)
    ) dut (
        .i_oszClk   (oszClk),
        .i_reset    (reset),
        .i_ioNCE    (ioNCE),
        .i_ioAddress(ioAddress),
        .i_ioNOE    (ioNOE),
        .i_ioNWE    (ioNWE),
        .i_bus      (busIn),
        .o_bus      (busOut),
        .o_busNOE   (busNOE),
        .i_switches (switches),
        .o_leds     (leds),
        .o_txData   (txData),
        .o_txValid  (txValid),
        .i_txReady  (txReady)
    );

    task automatic idleBus();
        ioNCE     = 1'b1;
        ioNOE     = 1'b1;
        ioNWE     = 1'b1;
        ioAddress = 8'h00;
        busIn     = 8'h00;
    endtask

    task automatic busWrite(input logic [7:0] addr, input logic [7:0] data, input int cycles);
        @(negedge oszClk);
        ioNCE = 1'b0; ioAddress = addr; busIn = data; ioNOE = 1'b1; ioNWE = 1'b0;
        repeat (cycles) @(negedge oszClk);
        idleBus();
    endtask

    task automatic busRead(input logic [7:0] addr, output logic [7:0] data, output logic noe);
        @(negedge oszClk);
        ioNCE = 1'b0; ioAddress = addr; ioNOE = 1'b0; ioNWE = 1'b1;
        #1;
        data = busOut;
        noe  = busNOE;
        @(negedge oszClk);
        idleBus();
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       n;
        reset = 1'b1; txReady = 1'b0; switches = 8'h00; busIn = 8'h00;
        ioNCE = 1'b0; ioAddress = 8'h01; ioNOE = 1'b0; ioNWE = 1'b1;
        #12;
        checks++; if (busNOE !== 1'b1) begin failures++; $display("FAIL reset_busNOE: got %b expected 1", busNOE); end
        checks++; if (busOut !== 8'h00) begin failures++; $display("FAIL reset_bus: got %h expected 00", busOut); end
        @(negedge oszClk);
        reset = 1'b0;
        idleBus();
        @(negedge oszClk);
        #1;
        checks++; if (leds !== 8'h00) begin failures++; $display("FAIL reset_leds: got %h expected 00", leds); end
        checks++; if (txValid !== 1'b0 || txData !== 8'h00) begin failures++; $display("FAIL reset_fifo: got valid=%b data=%h expected 0/00", txValid, txData); end
        busRead(8'h03, d, n);
        checks++; if (d !== 8'h01 || n !== 1'b0) begin failures++; $display("FAIL reset_status: got %h noe=%b expected 01 noe=0", d, n); end
    endtask

    task automatic test_switches();
        logic [7:0] d;
        logic       n;
        @(negedge oszClk);
        switches = 8'h06;
        @(negedge oszClk);
        ioNCE = 1'b0; ioAddress = 8'h01; ioNOE = 1'b0; ioNWE = 1'b1;
        #1;
        checks++; if (busOut !== 8'h00) begin failures++; $display("FAIL switch_lag1: got %h expected 00", busOut); end
        @(negedge oszClk);
        #1;
        checks++; if (busOut !== 8'h06 || busNOE !== 1'b0) begin failures++; $display("FAIL switch_read: got %h noe=%b expected 06 noe=0", busOut, busNOE); end
        @(negedge oszClk);
        idleBus();
        busRead(8'h00, d, n);
        checks++; if (n !== 1'b1 || d !== 8'h00) begin failures++; $display("FAIL addr00: got %h noe=%b expected 00 noe=1", d, n); end
        busRead(8'h06, d, n);
        checks++; if (n !== 1'b1 || d !== 8'h00) begin failures++; $display("FAIL addr06: got %h noe=%b expected 00 noe=1", d, n); end
    endtask

    task automatic test_leds();
        logic [7:0] d;
        logic       n;
        @(negedge oszClk);
        ioNCE = 1'b0; ioAddress = 8'h02; busIn = 8'hA5; ioNOE = 1'b0; ioNWE = 1'b0;
        #1;
        checks++; if (busNOE !== 1'b1) begin failures++; $display("FAIL write_noe: got %b expected 1", busNOE); end
        @(negedge oszClk);
        #1;
        checks++; if (leds !== 8'hA5) begin failures++; $display("FAIL leds_commit: got %h expected a5", leds); end
        busIn = 8'h5A;
        repeat (3) @(negedge oszClk);
        #1;
        checks++; if (leds !== 8'hA5) begin failures++; $display("FAIL leds_single: got %h expected a5", leds); end
        idleBus();
        busRead(8'h02, d, n);
        checks++; if (d !== 8'hA5) begin failures++; $display("FAIL leds_readback: got %h expected a5", d); end
    endtask

    task automatic test_fifo_overflow();
        logic [7:0] d;
        logic       n;
        txReady = 1'b0;
        for (int i = 0; i < 9; i++) busWrite(8'h04, 8'h10 + 8'(i), 1);
        busRead(8'h03, d, n);
        checks++; if (d !== 8'h86) begin failures++; $display("FAIL ovf_status: got %h expected 86", d); end
        busRead(8'h04, d, n);
        checks++; if (d !== 8'h10) begin failures++; $display("FAIL peek: got %h expected 10", d); end
        busRead(8'h03, d, n);
        checks++; if (d !== 8'h86) begin failures++; $display("FAIL peek_nopop: got %h expected 86", d); end
        busWrite(8'h03, 8'h00, 1);
        busRead(8'h03, d, n);
        checks++; if (d !== 8'h82) begin failures++; $display("FAIL status_clear: got %h expected 82", d); end
        @(negedge oszClk);
        txReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (txValid !== 1'b1 || txData !== 8'h10 + 8'(i)) begin
                failures++;
                $display("FAIL drain_%0d: got valid=%b data=%h expected 1/%h", i, txValid, txData, 8'h10 + 8'(i));
            end
            @(negedge oszClk);
        end
        #1;
        checks++; if (txValid !== 1'b0 || txData !== 8'h00) begin failures++; $display("FAIL drain_empty: got valid=%b data=%h expected 0/00", txValid, txData); end
        txReady = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic       n;
        logic [7:0] expSeq [8];
        for (int i = 0; i < 8; i++) busWrite(8'h04, 8'h20 + 8'(i), 1);
        @(negedge oszClk);
        txReady = 1'b1;
        ioNCE = 1'b0; ioAddress = 8'h04; busIn = 8'h55; ioNOE = 1'b1; ioNWE = 1'b0;
        @(negedge oszClk);
        txReady = 1'b0;
        idleBus();
        busRead(8'h03, d, n);
        checks++; if (d !== 8'h82) begin failures++; $display("FAIL b2b_status: got %h expected 82", d); end
        for (int i = 0; i < 7; i++) expSeq[i] = 8'h21 + 8'(i);
        expSeq[7] = 8'h55;
        @(negedge oszClk);
        txReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (txValid !== 1'b1 || txData !== expSeq[i]) begin
                failures++;
                $display("FAIL b2b_drain_%0d: got valid=%b data=%h expected 1/%h", i, txValid, txData, expSeq[i]);
            end
            @(negedge oszClk);
        end
        #1;
        checks++; if (txValid !== 1'b0) begin failures++; $display("FAIL b2b_empty: got valid=%b expected 0", txValid); end
        txReady = 1'b0;
    endtask

    task automatic test_underflow();
        logic [7:0] d;
        logic       n;
        busRead(8'h04, d, n);
        checks++; if (d !== 8'h00 || n !== 1'b0) begin failures++; $display("FAIL empty_peek: got %h noe=%b expected 00 noe=0", d, n); end
        busRead(8'h03, d, n);
        checks++; if (d !== 8'h09) begin failures++; $display("FAIL underflow_status: got %h expected 09", d); end
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] d;
        logic       n;
        @(negedge oszClk);
        ioNCE = 1'b0; ioAddress = 8'h05; busIn = 8'hFF; ioNOE = 1'b1; ioNWE = 1'b0;
        #2;
        reset = 1'b1;
        repeat (2) @(negedge oszClk);
        reset = 1'b0;
        repeat (2) @(negedge oszClk);
        idleBus();
        busRead(8'h05, d, n);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL scratch_abort: got %h expected 00", d); end
        busRead(8'h03, d, n);
        checks++; if (d !== 8'h01) begin failures++; $display("FAIL status_after_reset: got %h expected 01", d); end
        busWrite(8'h05, 8'h3C, 1);
        busRead(8'h05, d, n);
        checks++; if (d !== 8'h3C) begin failures++; $display("FAIL scratch_rw: got %h expected 3c", d); end
    endtask

    initial begin
        test_reset();
        test_switches();
        test_leds();
        test_fifo_overflow();
        test_back_to_back();
        test_underflow();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
